// File: rtl/draw_cmd_scheduler_pkg.sv
// Shared types and constants for the draw command scheduler.
// Includes the screen-bounds check used when SCHED_CLIP_EN is defined.
package draw_cmd_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_T_RST   = 3'd2,
        ST_T_RUN   = 3'd3,
        ST_L_START = 3'd4,
        ST_L_RUN   = 3'd5
    } sched_state_e;

    localparam logic CMD_LINE = 1'b0;
    localparam logic CMD_TRI  = 1'b1;

    localparam int SCR_W = 640;
    localparam int SCR_H = 480;

    typedef struct packed {
        logic               cmd_type;
        logic signed [31:0] x1;
        logic signed [31:0] y1;
        logic signed [31:0] x2;
        logic signed [31:0] y2;
        logic signed [31:0] x3;
        logic signed [31:0] y3;
    } draw_cmd_t;

    localparam int CMD_W = $bits(draw_cmd_t);

    function automatic logic coord_ok(input logic signed [31:0] x, input logic signed [31:0] y);
        return (x >= 0) && (x < SCR_W) && (y >= 0) && (y < SCR_H);
    endfunction

    // Lines ignore the third vertex, so only triangles check it.
    function automatic logic cmd_on_screen(input draw_cmd_t c);
        logic ok;
        ok = coord_ok(c.x1, c.y1) && coord_ok(c.x2, c.y2);
        if (c.cmd_type == CMD_TRI) ok = ok && coord_ok(c.x3, c.y3);
        return ok;
    endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// Synchronous FIFO for draw commands with a registered full flag and an occupancy count.
module draw_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push while full is only taken when the same cycle frees a slot.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10: begin
                    count <= count + 1'b1;
                    full  <= (count == LAST);
                end
                2'b01: begin
                    count <= count - 1'b1;
                    full  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/draw_cmd_scheduler.sv
// Draw command front-end: queues line/triangle commands and issues them in order to the raster engines.
// Define SCHED_CLIP_EN to discard off-screen commands and expose drop_cnt.
module draw_cmd_scheduler
    import draw_cmd_scheduler_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TRI_RST_CYCLES = 2,
    parameter int TIMEOUT        = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_type,
    input  logic signed [31:0] x1,
    input  logic signed [31:0] y1,
    input  logic signed [31:0] x2,
    input  logic signed [31:0] y2,
    input  logic signed [31:0] x3,
    input  logic signed [31:0] y3,
    output logic               line_start,
    output logic signed [31:0] lx1,
    output logic signed [31:0] ly1,
    output logic signed [31:0] lx2,
    output logic signed [31:0] ly2,
    input  logic               line_finish,
    output logic               tri_reset,
    output logic signed [31:0] tx1,
    output logic signed [31:0] ty1,
    output logic signed [31:0] tx2,
    output logic signed [31:0] ty2,
    output logic signed [31:0] tx3,
    output logic signed [31:0] ty3,
    input  logic               tri_finish,
    input  logic [9:0]         line_px,
    input  logic [8:0]         line_py,
    input  logic [9:0]         tri_px,
    input  logic [8:0]         tri_py,
    output logic [9:0]         px,
    output logic [8:0]         py,
    output logic               pix_valid,
    output logic               busy,
    output logic               err_timeout,
`ifdef SCHED_CLIP_EN
    output logic [15:0]        drop_cnt,
`endif
    output logic [2:0]         dbg_state
);
    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_LOAD    = ST_LOAD;
    localparam logic [2:0] S_T_RST   = ST_T_RST;
    localparam logic [2:0] S_T_RUN   = ST_T_RUN;
    localparam logic [2:0] S_L_START = ST_L_START;
    localparam logic [2:0] S_L_RUN   = ST_L_RUN;

    logic [2:0]              state;
    logic [2:0]              state_nxt;
    logic [15:0]             cnt;
    logic                    cur_tri;
    draw_cmd_t               cmd_in;
    draw_cmd_t               cmd_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    issue;
    logic                    in_run;
    logic                    run_finish;
    logic                    timeout_hit;

    always_comb begin
        cmd_in.cmd_type = cmd_type;
        cmd_in.x1 = x1;
        cmd_in.y1 = y1;
        cmd_in.x2 = x2;
        cmd_in.y2 = y2;
        cmd_in.x3 = x3;
        cmd_in.y3 = y3;
    end

    // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready.
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_pop  = (state == S_IDLE) && !fifo_empty;

    draw_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .pop_data  (cmd_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef SCHED_CLIP_EN
    assign issue = fifo_pop && cmd_on_screen(cmd_head);
`else
    assign issue = fifo_pop;
`endif

    assign in_run      = (state == S_T_RUN) || (state == S_L_RUN);
    assign run_finish  = ((state == S_T_RUN) && tri_finish) || ((state == S_L_RUN) && line_finish);
    // cnt counts completed run cycles, so the abort lands TIMEOUT cycles after run entry.
    assign timeout_hit = (TIMEOUT != 0) && (({1'b0, cnt} + 17'd1) == 17'(TIMEOUT));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (issue) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = cur_tri ? S_T_RST : S_L_START;
            S_T_RST:   if (({1'b0, cnt} + 17'd1) >= 17'(TRI_RST_CYCLES)) state_nxt = S_T_RUN;
            S_T_RUN:   if (tri_finish || timeout_hit) state_nxt = S_IDLE;
            S_L_START: state_nxt = S_L_RUN;
            S_L_RUN:   if (line_finish || timeout_hit) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cur_tri     <= 1'b0;
            err_timeout <= 1'b0;
            lx1 <= '0; ly1 <= '0; lx2 <= '0; ly2 <= '0;
            tx1 <= '0; ty1 <= '0; tx2 <= '0; ty2 <= '0; tx3 <= '0; ty3 <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)  cnt <= '0;
            else if (state != S_IDLE) cnt <= cnt + 16'd1;

            if (issue) begin
                cur_tri <= cmd_head.cmd_type;
                if (cmd_head.cmd_type == CMD_TRI) begin
                    tx1 <= cmd_head.x1; ty1 <= cmd_head.y1;
                    tx2 <= cmd_head.x2; ty2 <= cmd_head.y2;
                    tx3 <= cmd_head.x3; ty3 <= cmd_head.y3;
                end else begin
                    lx1 <= cmd_head.x1; ly1 <= cmd_head.y1;
                    lx2 <= cmd_head.x2; ly2 <= cmd_head.y2;
                end
            end else if (in_run && (state_nxt == S_IDLE)) begin
                lx1 <= '0; ly1 <= '0; lx2 <= '0; ly2 <= '0;
                tx1 <= '0; ty1 <= '0; tx2 <= '0; ty2 <= '0; tx3 <= '0; ty3 <= '0;
            end

            // A finish in the abort cycle wins: the command completed.
            if (in_run && timeout_hit && !run_finish) err_timeout <= 1'b1;
        end
    end

`ifdef SCHED_CLIP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (fifo_pop && !issue && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

    always_comb begin
        px        = '0;
        py        = '0;
        pix_valid = 1'b0;
        if (state == S_T_RUN) begin
            px        = tri_px;
            py        = tri_py;
            pix_valid = (tri_px != '0) || (tri_py != '0);
        end else if (state == S_L_RUN) begin
            px        = line_px;
            py        = line_py;
            pix_valid = 1'b1;
        end
    end

    assign line_start = (state == S_L_START);
    assign tri_reset  = (state != S_T_RUN);
    assign busy       = (state != S_IDLE) || (fifo_count != '0);
    assign dbg_state  = state;

endmodule
